// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: command sequencer behind the UART receiver.
// Parses [W][addr][data] write packets and [R][addr] read packets from the
// received byte stream, issues register writes / read requests and returns
// read data through the UART TX handshake.
// Optional build macro UART_CMD_CSUM_EN: each packet carries a trailing byte
// equal to the XOR of all preceding packet bytes, checked before issuing.
//
// Handshakes: o_rd_valid is held with a stable o_rd_addr until a cycle with
// i_rd_ack high (i_rd_data sampled in that cycle); o_tx_valid is held with a
// stable o_tx_data until a cycle with i_tx_ready high. i_rx_valid is a
// one-cycle pulse with no back-pressure.
module uart_cmd_ctrl #(
    parameter int          p_timeout = 100000,
    parameter logic [7:0]  p_op_wr   = 8'h57,
    parameter logic [7:0]  p_op_rd   = 8'h52
) (
    input  logic       i_clk,
    input  logic       i_nrst,
    input  logic       i_rx_valid,
    input  logic [7:0] i_rx_data,
    output logic       o_wr_valid,
    output logic [7:0] o_wr_addr,
    output logic [7:0] o_wr_data,
    output logic       o_rd_valid,
    output logic [7:0] o_rd_addr,
    input  logic       i_rd_ack,
    input  logic [7:0] i_rd_data,
    output logic       o_tx_valid,
    output logic [7:0] o_tx_data,
    input  logic       i_tx_ready,
    output logic       o_err,
    output logic       o_busy
);

    localparam int              TW   = $clog2(p_timeout + 1);
    localparam logic [TW-1:0]   TMAX = TW'(p_timeout);

`ifdef UART_CMD_CSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_CSUM, S_WR, S_RD_REQ, S_TX
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_WR, S_RD_REQ, S_TX
    } state_t;
`endif

    state_t        state;
    logic          is_wr;
    logic [7:0]    addr;
    logic [7:0]    data;
    logic [7:0]    tx_data;
    logic [TW-1:0] timer;
    logic          wr_valid;
    logic          rd_valid;
    logic          tx_valid;
    logic          err;
`ifdef UART_CMD_CSUM_EN
    logic [7:0]    csum;
`endif

    // Packet FSM with registered strobes. The timer counts idle cycles while
    // waiting for the next packet byte; a byte in the timeout cycle wins.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state    <= S_IDLE;
            is_wr    <= 1'b0;
            addr     <= '0;
            data     <= '0;
            tx_data  <= '0;
            timer    <= '0;
            wr_valid <= 1'b0;
            rd_valid <= 1'b0;
            tx_valid <= 1'b0;
            err      <= 1'b0;
`ifdef UART_CMD_CSUM_EN
            csum     <= '0;
`endif
        end else begin
            wr_valid <= 1'b0;
            err      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_rx_valid) begin
                        if (i_rx_data == p_op_wr || i_rx_data == p_op_rd) begin
                            state <= S_ADDR;
                            is_wr <= (i_rx_data == p_op_wr);
                            timer <= '0;
`ifdef UART_CMD_CSUM_EN
                            csum  <= i_rx_data;
`endif
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_ADDR: begin
                    if (i_rx_valid) begin
                        addr  <= i_rx_data;
                        timer <= '0;
`ifdef UART_CMD_CSUM_EN
                        csum  <= csum ^ i_rx_data;
                        state <= is_wr ? S_DATA : S_CSUM;
`else
                        if (is_wr) begin
                            state <= S_DATA;
                        end else begin
                            state    <= S_RD_REQ;
                            rd_valid <= 1'b1;
                        end
`endif
                    end else if (timer == TMAX) begin
                        state <= S_IDLE;
                        err   <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_DATA: begin
                    if (i_rx_valid) begin
                        data  <= i_rx_data;
                        timer <= '0;
`ifdef UART_CMD_CSUM_EN
                        csum  <= csum ^ i_rx_data;
                        state <= S_CSUM;
`else
                        state    <= S_WR;
                        wr_valid <= 1'b1;
`endif
                    end else if (timer == TMAX) begin
                        state <= S_IDLE;
                        err   <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
`ifdef UART_CMD_CSUM_EN
                S_CSUM: begin
                    if (i_rx_valid) begin
                        timer <= '0;
                        if (i_rx_data != csum) begin
                            state <= S_IDLE;
                            err   <= 1'b1;
                        end else if (is_wr) begin
                            state    <= S_WR;
                            wr_valid <= 1'b1;
                        end else begin
                            state    <= S_RD_REQ;
                            rd_valid <= 1'b1;
                        end
                    end else if (timer == TMAX) begin
                        state <= S_IDLE;
                        err   <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
`endif
                S_WR: begin
                    state <= S_IDLE;
                    err   <= i_rx_valid;
                end
                S_RD_REQ: begin
                    err <= i_rx_valid;
                    if (i_rd_ack) begin
                        rd_valid <= 1'b0;
                        tx_data  <= i_rd_data;
                        tx_valid <= 1'b1;
                        state    <= S_TX;
                    end
                end
                S_TX: begin
                    err <= i_rx_valid;
                    if (i_tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_wr_valid = wr_valid;
    assign o_wr_addr  = addr;
    assign o_wr_data  = data;
    assign o_rd_valid = rd_valid;
    assign o_rd_addr  = addr;
    assign o_tx_valid = tx_valid;
    assign o_tx_data  = tx_data;
    assign o_err      = err;
    assign o_busy     = (state != S_IDLE);

endmodule
